// File: rtl/seq_dbg_cmd_ctrl_if.sv
// seq_dbg_cmd_ctrl_if: Avalon-MM bus between the debug command controller and the sequencer slave port.
//   address       master->slave  byte address
//   read/write    master->slave  access strobes (never both high)
//   writedata     master->slave  write data
//   readdata      slave->master  read data, qualified by readdatavalid
//   readdatavalid slave->master  read data strobe
//   waitrequest   slave->master  stall; master holds strobe/address/data while high
interface seq_dbg_cmd_ctrl_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        waitrequest;
    modport master (output address, read, write, writedata, input readdata, readdatavalid, waitrequest);
    modport slave  (input address, read, write, writedata, output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/seq_dbg_cmd_ctrl.sv
// seq_dbg_cmd_ctrl: drives the sequencer debug command mailbox (params, command, status polling) for one requester.
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready high only when idle
//   cmd_code              value written to REQ_CMD
//   cmd_nparams           parameter word count, clamped to NUM_PARAMS
//   cmd_params            parameter words, word i at [32i+31:32i]
//   resp_valid/resp_ready response handshake; response held until accepted
//   resp_status           last CMD_STATUS value read
//   resp_error            status matched STATUS_ERR
//   resp_timeout          POLL_TIMEOUT status reads without done/error
//   resp_result           CMD_PARAMS+0 read back after done (SEQ_DBG_RESULT_READBACK_EN), else 0
//   busy                  controller not idle
//   avl                   Avalon-MM master port
// Define SEQ_DBG_RESULT_READBACK_EN to read CMD_PARAMS+0 back into resp_result after a successful command.
module seq_dbg_cmd_ctrl #(
    parameter logic [31:0] CMD_BASE     = 32'h0001_53BC,
    parameter int          NUM_PARAMS   = 4,
    parameter logic [31:0] STATUS_DONE  = 32'h0000_0001,
    parameter logic [31:0] STATUS_ERR   = 32'h0000_0002,
    parameter int          POLL_GAP     = 8,
    parameter int          POLL_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_code,
    input  logic [3:0]                cmd_nparams,
    input  logic [32*NUM_PARAMS-1:0]  cmd_params,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_status,
    output logic                      resp_error,
    output logic                      resp_timeout,
    output logic [31:0]               resp_result,
    output logic                      busy,
    seq_dbg_cmd_ctrl_if.master        avl
);
    localparam int IW = NUM_PARAMS > 1 ? $clog2(NUM_PARAMS) : 1;
    localparam int PW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_PARAM  = 4'd1;
    localparam logic [3:0] S_WR_CMD    = 4'd2;
    localparam logic [3:0] S_POLL_RD   = 4'd3;
    localparam logic [3:0] S_POLL_WAIT = 4'd4;
    localparam logic [3:0] S_GAP       = 4'd5;
    localparam logic [3:0] S_RSP       = 4'd6;
`ifdef SEQ_DBG_RESULT_READBACK_EN
    localparam logic [3:0] S_DONE_RD   = 4'd7;
    localparam logic [3:0] S_DONE_WT   = 4'd8;
    localparam logic [3:0] S_ON_DONE   = S_DONE_RD;
    logic [31:0] res_q;
`else
    localparam logic [3:0] S_ON_DONE   = S_RSP;
`endif

    logic [3:0]              state;
    logic [31:0]             code;
    logic [3:0]              np;
    logic [32*NUM_PARAMS-1:0] prm;
    logic [3:0]              idx;
    logic [PW-1:0]           poll_cnt;
    logic [PW-1:0]           poll_nxt;
    logic [7:0]              gap_cnt;
    logic [3:0]              np_c;
    logic [31:0]             rd;

    assign np_c     = cmd_nparams > 4'(NUM_PARAMS) ? 4'(NUM_PARAMS) : cmd_nparams;
    assign poll_nxt = poll_cnt + PW'(1);
    assign rd       = avl.readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            code         <= '0;
            np           <= '0;
            prm          <= '0;
            idx          <= '0;
            poll_cnt     <= '0;
            gap_cnt      <= '0;
            resp_status  <= '0;
            resp_error   <= 1'b0;
            resp_timeout <= 1'b0;
`ifdef SEQ_DBG_RESULT_READBACK_EN
            res_q        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    code  <= cmd_code;
                    np    <= np_c;
                    prm   <= cmd_params;
                    idx   <= '0;
                    state <= np_c == 4'd0 ? S_WR_CMD : S_WR_PARAM;
                end
                S_WR_PARAM: if (!avl.waitrequest) begin
                    idx <= idx + 4'd1;
                    if (idx == np - 4'd1) state <= S_WR_CMD;
                end
                S_WR_CMD: if (!avl.waitrequest) begin
                    poll_cnt <= '0;
                    state    <= S_POLL_RD;
                end
                S_POLL_RD: if (!avl.waitrequest) state <= S_POLL_WAIT;
                // done and error take priority over timeout on the final permitted poll
                S_POLL_WAIT: if (avl.readdatavalid) begin
                    resp_status <= rd;
                    poll_cnt    <= poll_nxt;
                    if (rd == STATUS_DONE) state <= S_ON_DONE;
                    else if (rd == STATUS_ERR) begin
                        resp_error <= 1'b1;
                        state      <= S_RSP;
                    end else if (poll_nxt == PW'(POLL_TIMEOUT)) begin
                        resp_timeout <= 1'b1;
                        state        <= S_RSP;
                    end else begin
                        gap_cnt <= 8'(POLL_GAP - 1);
                        state   <= POLL_GAP == 0 ? S_POLL_RD : S_GAP;
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd0) state <= S_POLL_RD;
                end
`ifdef SEQ_DBG_RESULT_READBACK_EN
                S_DONE_RD: if (!avl.waitrequest) state <= S_DONE_WT;
                S_DONE_WT: if (avl.readdatavalid) begin
                    res_q <= rd;
                    state <= S_RSP;
                end
`endif
                S_RSP: if (resp_ready) begin
                    resp_error   <= 1'b0;
                    resp_timeout <= 1'b0;
`ifdef SEQ_DBG_RESULT_READBACK_EN
                    res_q        <= '0;
`endif
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // bus outputs decode straight from registered state, so they hold while stalled and drop on reset
    assign cmd_ready  = state == S_IDLE;
    assign busy       = state != S_IDLE;
    assign resp_valid = state == S_RSP;
    assign avl.write  = state == S_WR_PARAM || state == S_WR_CMD;
`ifdef SEQ_DBG_RESULT_READBACK_EN
    assign resp_result = res_q;
    assign avl.read    = state == S_POLL_RD || state == S_DONE_RD;
    assign avl.address = state == S_WR_PARAM ? CMD_BASE + 32'd8 + 32'({idx, 2'b00}) :
                         state == S_WR_CMD   ? CMD_BASE :
                         state == S_POLL_RD  ? CMD_BASE + 32'd4 :
                         state == S_DONE_RD  ? CMD_BASE + 32'd8 : '0;
`else
    assign resp_result = '0;
    assign avl.read    = state == S_POLL_RD;
    assign avl.address = state == S_WR_PARAM ? CMD_BASE + 32'd8 + 32'({idx, 2'b00}) :
                         state == S_WR_CMD   ? CMD_BASE :
                         state == S_POLL_RD  ? CMD_BASE + 32'd4 : '0;
`endif
    assign avl.writedata = state == S_WR_PARAM ? prm[{idx[IW-1:0], 5'b00000} +: 32] :
                           state == S_WR_CMD   ? code : '0;
endmodule

// File: tb/tb_seq_dbg_cmd_ctrl.sv
// tb_seq_dbg_cmd_ctrl: directed scoreboard bench with a reactive Avalon slave model.
module tb_seq_dbg_cmd_ctrl;
`ifdef SEQ_DBG_RESULT_READBACK_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam logic [31:0] A_REQ = 32'h0001_53BC;
    localparam logic [31:0] A_ST  = 32'h0001_53C0;
    localparam logic [31:0] A_PRM = 32'h0001_53C4;
    localparam logic [31:0] RES_VAL = 32'hDEAD_BEEF;
    localparam int GAP = 8;

    typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} acc_t;
    typedef struct packed {logic [31:0] st; logic er; logic to; logic [31:0] res;} rsp_t;

    logic clk = 1'b0;
    logic reset;
    logic cmd_valid, cmd_ready, resp_valid, resp_ready, resp_error, resp_timeout, busy;
    logic [31:0] cmd_code, resp_status, resp_result;
    logic [3:0] cmd_nparams;
    logic [127:0] cmd_params;

    seq_dbg_cmd_ctrl_if avl ();

    seq_dbg_cmd_ctrl #(.POLL_GAP(GAP), .POLL_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
        .cmd_nparams(cmd_nparams), .cmd_params(cmd_params),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_status(resp_status),
        .resp_error(resp_error), .resp_timeout(resp_timeout), .resp_result(resp_result),
        .busy(busy), .avl(avl)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, acc_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    acc_t exp_q[$];
    rsp_t rsp_q[$];
    logic [31:0] st_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int stall = 0, rd_delay = 0, left = 0, rd_cnt = 0, last_rdv = -1;
    bit in_acc = 1'b0;
    logic w0, rd_stat;
    logic [31:0] a0, d0, rd_val;

    always @(negedge clk) begin
        acc_t e;
        avl.readdatavalid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                avl.readdatavalid = 1'b1;
                avl.readdata = rd_val;
                if (rd_stat) last_rdv = cyc;
            end
        end
        chk("rw_excl", 64'(avl.read & avl.write), 0);
        if (avl.read || avl.write) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                left = stall;
                a0 = avl.address; d0 = avl.writedata; w0 = avl.write;
                if (avl.read && avl.address == A_ST && last_rdv >= 0)
                    chk("poll_gap", 64'(cyc - last_rdv), GAP + 1);
            end else begin
                chk("hold_addr", avl.address, a0);
                chk("hold_we", avl.write, w0);
                if (w0) chk("hold_data", avl.writedata, d0);
            end
            if (left > 0) begin
                left--;
                avl.waitrequest = 1'b1;
            end else begin
                avl.waitrequest = 1'b0;
                in_acc = 1'b0;
                chk("acc_pending", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("acc_we", avl.write, e.we);
                    chk("acc_addr", avl.address, e.addr);
                    if (e.we) chk("acc_data", avl.writedata, e.data);
                end
                if (avl.write && avl.address == A_REQ) last_rdv = -1;
                if (avl.read) begin
                    rd_cnt = rd_delay + 1;
                    rd_stat = avl.address == A_ST;
                    rd_val = !rd_stat ? RES_VAL : (st_q.size() > 0 ? st_q.pop_front() : 32'h0);
                end
            end
        end else begin
            avl.waitrequest = 1'b0;
            in_acc = 1'b0;
        end
    end

    task automatic send(input logic [31:0] code, input logic [3:0] np, input logic [127:0] prm,
                        input int npolls, input logic [31:0] last_st, input bit want_resp);
        int ne = np > 4'd4 ? 4 : int'(np);
        bit dn = last_st == 32'd1;
        bit er = last_st == 32'd2;
        for (int i = 0; i < ne; i++) exp_q.push_back('{1'b1, A_PRM + 32'(4 * i), prm[32*i +: 32]});
        exp_q.push_back('{1'b1, A_REQ, code});
        for (int i = 0; i < npolls; i++) begin
            exp_q.push_back('{1'b0, A_ST, 32'h0});
            st_q.push_back(i == npolls - 1 ? last_st : 32'h0);
        end
        if (FEAT && dn) exp_q.push_back('{1'b0, A_PRM, 32'h0});
        if (want_resp) rsp_q.push_back('{last_st, er, !dn && !er, (FEAT && dn) ? RES_VAL : 32'h0});
        @(negedge clk);
        cmd_valid = 1'b1; cmd_code = code; cmd_nparams = np; cmd_params = prm;
        for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0; cmd_code = '0; cmd_nparams = '0; cmd_params = '0;
    endtask

    task automatic wait_resp(input int hold, input int lat);
        rsp_t r;
        for (int i = 0; i < 2000 && !resp_valid; i++) @(negedge clk);
        chk("resp_seen", resp_valid, 1);
        r = rsp_q.pop_front();
        if (lat >= 0) chk("latency", 64'(cyc - acc_cyc + 1), 64'(lat));
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            chk("resp_valid", resp_valid, 1);
            chk("resp_status", resp_status, r.st);
            chk("resp_error", resp_error, r.er);
            chk("resp_timeout", resp_timeout, r.to);
            chk("resp_result", resp_result, r.res);
            chk("rsp_cmd_ready", cmd_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", resp_valid, 0);
        chk("post_error", resp_error, 0);
        chk("post_timeout", resp_timeout, 0);
        chk("post_ready", cmd_ready, 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_read"}, avl.read, 0);
        chk({tag, "_write"}, avl.write, 0);
        chk({tag, "_address"}, avl.address, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_nparams = '0; cmd_params = '0;
        resp_ready = 1'b0;
        avl.readdata = '0; avl.readdatavalid = 1'b0; avl.waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_writedata", avl.writedata, 0);
        chk("rst_status", resp_status, 0);
        chk("rst_error", resp_error, 0);
        chk("rst_timeout", resp_timeout, 0);
        chk("rst_result", resp_result, 0);
        reset = 1'b0;

        send(32'h21, 4'd2, {32'h0, 32'h0, 32'h5A, 32'hA5}, 1, 32'd1, 1'b1);
        wait_resp(5, 6 + (FEAT ? 2 : 0));

        stall = 3;
        send(32'h21, 4'd2, {32'h0, 32'h0, 32'h5A, 32'hA5}, 1, 32'd1, 1'b1);
        wait_resp(0, 18 + (FEAT ? 5 : 0));
        stall = 0;

        send(32'h33, 4'd0, '0, 5, 32'd2, 1'b1);
        wait_resp(0, -1);

        send(32'h44, 4'd1, {96'h0, 32'h77}, 16, 32'd0, 1'b1);
        wait_resp(0, -1);

        send(32'h45, 4'd1, {96'h0, 32'h78}, 16, 32'd1, 1'b1);
        wait_resp(1, -1);

        send(32'h55, 4'd9, {32'h44, 32'h33, 32'h22, 32'h11}, 1, 32'd1, 1'b1);
        wait_resp(0, 8 + (FEAT ? 2 : 0));

        rd_delay = 4;
        send(32'h66, 4'd0, '0, 1, 32'd1, 1'b0);
        for (int i = 0; i < 50 && !avl.read; i++) @(negedge clk);
        chk("rst_rd_seen", avl.read, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle("midrst");
        rd_delay = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stale_resp_valid", resp_valid, 0);
            chk("stale_busy", busy, 0);
        end

        send(32'h77, 4'd3, {32'h0, 32'hC3, 32'hB2, 32'hA1}, 2, 32'd1, 1'b1);
        wait_resp(2, -1);

        repeat (4) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 0);
        chk("st_q_empty", 64'(st_q.size()), 0);
        chk("rsp_q_empty", 64'(rsp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seq_dbg_cmd_ctrl.md
Name: seq_dbg_cmd_ctrl

Overview:
- Avalon-MM master that drives the sequencer core debug command mailbox on behalf of one requester (test logic or JTAG bridge).
- Per command: writes up to NUM_PARAMS parameter words to the PARAMS window, writes the command code to REQ_CMD, then polls CMD_STATUS until done, error or timeout.
- Returns the final status through a valid/ready response port. Sits between the memory-test control logic and the sequencer's Avalon slave port.

Parameters:
- CMD_BASE, 32'h0001_53BC, byte address of the command block. REQ_CMD = CMD_BASE+0, CMD_STATUS = CMD_BASE+4, CMD_PARAMS = CMD_BASE+8.
- NUM_PARAMS, 4, maximum parameter words per command (1..8).
- STATUS_DONE, 32'h0000_0001, status value meaning success.
- STATUS_ERR, 32'h0000_0002, status value meaning failure.
- POLL_GAP, 8, idle cycles between status reads (0..255).
- POLL_TIMEOUT, 1024, maximum status reads before timeout (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_code  in  32  value written to REQ_CMD
- cmd_nparams  in  4  number of parameter words to write (0..NUM_PARAMS)
- cmd_params  in  32*NUM_PARAMS  word i at bits [32i+31:32i]
- resp_valid  out  1  response available, held until accepted
- resp_ready  in  1  response accept
- resp_status  out  32  last CMD_STATUS value read
- resp_error  out  1  status matched STATUS_ERR
- resp_timeout  out  1  POLL_TIMEOUT reached
- resp_result  out  32  see Optional Feature
- busy  out  1  state != IDLE
- avl_address  out  32  byte address
- avl_read  out  1  read strobe
- avl_write  out  1  write strobe
- avl_writedata  out  32  write data
- avl_readdata  in  32  read data
- avl_readdatavalid  in  1  read data strobe
- avl_waitrequest  in  1  slave stall

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs 0 except cmd_ready=1. Counters cleared. A readdatavalid arriving after reset is ignored.
- Handshake: a command is accepted when cmd_valid&&cmd_ready. Code, nparams and params are captured into registers that cycle. cmd_nparams>NUM_PARAMS is clamped to NUM_PARAMS.
- Avalon rules:
  - A strobe plus its address/data is held stable while avl_waitrequest=1. The access completes on the first edge with waitrequest=0, and the strobe drops or advances on that edge.
  - Only one read is outstanding. No new access is issued until its readdatavalid arrives.
  - avl_read and avl_write are never high together.
- States:
  - IDLE: on accept, go to WR_PARAM if nparams>0, else WR_CMD.
  - WR_PARAM: write param[i] to CMD_PARAMS+4*i for i=0..nparams-1, in order. After the last write completes, go to WR_CMD.
  - WR_CMD: write cmd_code to REQ_CMD. On completion, clear poll count and go to POLL_RD.
  - POLL_RD: issue a read of CMD_STATUS. On acceptance, go to POLL_WAIT.
  - POLL_WAIT: on readdatavalid, latch resp_status and increment the poll count. Then, with priority in this order:
    - ==STATUS_DONE → DONE_RD (feature on) or RSP (feature off).
    - ==STATUS_ERR → RSP with resp_error=1.
    - count==POLL_TIMEOUT → RSP with resp_timeout=1.
    - else → GAP.
  - GAP: wait POLL_GAP cycles, then POLL_RD. With POLL_GAP=0, go straight to POLL_RD on the next cycle.
  - RSP: resp_valid=1 with stable outputs. When resp_ready=1, go to IDLE; resp_valid and the flags clear on that edge.
- Done and error are each checked before timeout: a done/error on the final permitted poll is reported as done/error, not timeout.
- Minimum latency (waitrequest=0, readdatavalid one cycle after accept, done on first poll, feature off):
  - accept at cycle 0;
  - nparams writes;
  - cmd write;
  - read accepted, data next cycle;
  - resp_valid at cycle nparams+4.
- Reset mid-operation: an Avalon strobe drops on the reset edge and no response is produced.

Optional Feature:
- Macro SEQ_DBG_RESULT_READBACK_EN.
- Defined: on done, DONE_RD reads CMD_PARAMS+0 and latches it into resp_result, then goes to RSP. This adds one read transaction. It does not apply to error or timeout responses; for those resp_result=0.
- Undefined: no DONE_RD state and resp_result is tied to 0.

Test Plan:
- cmd_code=0x21, nparams=2, params {0xA5,0x5A}; slave returns status 1 on first poll:
  - writes 0x53C4←0xA5, 0x53C8←0x5A, 0x53BC←0x21, one read of 0x53C0;
  - resp_status=1, flags 0, resp_valid at cycle 6.
- avl_waitrequest high for 3 cycles on every access: address/data/strobe held stable; same transaction order; latency grows by 3 per access.
- Status returns 0 for 4 polls then 2, POLL_GAP=8: 8 idle cycles between reads; resp_error=1, resp_status=2 after 5 reads.
- POLL_TIMEOUT=16, status always 0: exactly 16 reads, then resp_timeout=1, resp_status=0. A variant with status 1 on read 16 gives done with resp_timeout=0.
- reset asserted during POLL_WAIT; stale readdatavalid arrives after reset: idle outputs next cycle, no resp_valid, cmd_ready=1; a following command runs normally.
- Feature on, CMD_PARAMS+0 returns 0xDEAD_BEEF after done: extra read of 0x53C4; resp_result=0xDEADBEEF. resp_ready held low for 5 cycles: outputs stable and cmd_ready=0 until accepted.
